// File: rtl/fft_frame_arbiter.sv
// Round-robin arbiter sharing one FFT core between two frame producers, with per-channel holding buffers.
// Optional overrun counters (ovr_cnt0/ovr_cnt1) are compiled in when FFT_ARB_OVR_CNT_EN is defined.
module fft_frame_arbiter #(
  parameter int DATA_W  = 16,
  parameter int NPTS    = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [NPTS*DATA_W-1:0] frm0,
  input  logic                   req1_valid,
  input  logic [NPTS*DATA_W-1:0] frm1,
  output logic                   fft_start,
  output logic                   fft_ch,
  output logic [NPTS*DATA_W-1:0] fft_din,
  input  logic                   fft_done,
  output logic                   frame_done,
  output logic                   done_ch,
  output logic                   busy,
  output logic                   ovr0,
  output logic                   ovr1,
  input  logic                   ovr_clr,
  output logic                   timeout
`ifdef FFT_ARB_OVR_CNT_EN
  ,
  output logic [7:0]             ovr_cnt0,
  output logic [7:0]             ovr_cnt1
`endif
);

  localparam int FW   = NPTS * DATA_W;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic              req0_prev, req1_prev;
  logic [FW-1:0]     buf0, buf1;
  logic              pend0, pend1;
  logic              last_grant;
  logic [WD_W-1:0]   wd_cnt;
  logic              rise0, rise1;
  logic              grant0, grant1;
  logic              take0, take1;
  logic              ovr_evt0, ovr_evt1;
  logic              wd_hit;

  assign rise0  = req0_valid & ~req0_prev;
  assign rise1  = req1_valid & ~req1_prev;
  // With both pending, the channel that did not win last time goes next.
  assign grant0 = pend0 & (~pend1 | last_grant);
  assign grant1 = pend1 & (~pend0 | ~last_grant);
  assign take0  = (state == S_IDLE) & grant0;
  assign take1  = (state == S_IDLE) & grant1;
  // A capture that lands while the buffer is being handed to the FFT is a refill, not an overrun.
  assign ovr_evt0 = rise0 & pend0 & ~take0;
  assign ovr_evt1 = rise1 & pend1 & ~take1;
  assign wd_hit   = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant0 | grant1) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (fft_done || wd_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fft_start = (state == S_START);
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req0_prev  <= 1'b0;
      req1_prev  <= 1'b0;
      buf0       <= '0;
      buf1       <= '0;
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      last_grant <= 1'b1;
      fft_ch     <= 1'b0;
      fft_din    <= '0;
      frame_done <= 1'b0;
      done_ch    <= 1'b0;
      timeout    <= 1'b0;
      wd_cnt     <= '0;
      ovr0       <= 1'b0;
      ovr1       <= 1'b0;
    end else begin
      req0_prev  <= req0_valid;
      req1_prev  <= req1_valid;
      if (rise0) buf0 <= frm0;
      if (rise1) buf1 <= frm1;
      pend0 <= rise0 | (pend0 & ~take0);
      pend1 <= rise1 | (pend1 & ~take1);
      if (take0) begin
        fft_din    <= buf0;
        fft_ch     <= 1'b0;
        last_grant <= 1'b0;
      end else if (take1) begin
        fft_din    <= buf1;
        fft_ch     <= 1'b1;
        last_grant <= 1'b1;
      end
      frame_done <= (state == S_WAIT) & fft_done;
      if ((state == S_WAIT) && fft_done) done_ch <= fft_ch;
      timeout <= (state == S_WAIT) & ~fft_done & wd_hit;
      wd_cnt  <= (state == S_WAIT) ? wd_cnt + 1'b1 : '0;
      ovr0    <= (ovr0 & ~ovr_clr) | ovr_evt0;
      ovr1    <= (ovr1 & ~ovr_clr) | ovr_evt1;
    end
  end

`ifdef FFT_ARB_OVR_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A clear coinciding with an overrun leaves that overrun counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt0 <= 8'd0;
      ovr_cnt1 <= 8'd0;
    end else begin
      if (ovr_clr)       ovr_cnt0 <= ovr_evt0 ? 8'd1 : 8'd0;
      else if (ovr_evt0) ovr_cnt0 <= sat_inc(ovr_cnt0);
      if (ovr_clr)       ovr_cnt1 <= ovr_evt1 ? 8'd1 : 8'd0;
      else if (ovr_evt1) ovr_cnt1 <= sat_inc(ovr_cnt1);
    end
  end
`endif

endmodule

// File: doc/fft_frame_arbiter.md
Name: fft_frame_arbiter

Overview:
- Shares one 16-point FFT core between two serial-to-parallel frame producers (channel 0, channel 1).
- Captures each completed frame into a per-channel holding buffer, so a producer can keep shifting new samples while its frame waits.
- Grants the FFT round-robin and sequences the start/done handshake.
- Reports overruns, timeouts and frame completions to the control/status logic.

Parameters:
- DATA_W, 16, sample width in bits.
- NPTS, 16, samples per frame.
- TIMEOUT, 255, maximum cycles in WAIT before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  channel 0 frame-ready level from its producer; may stay high for many cycles
- frm0  in  NPTS*DATA_W  channel 0 frame; sample i at bits [i*DATA_W +: DATA_W]
- req1_valid  in  1  channel 1 frame-ready level
- frm1  in  NPTS*DATA_W  channel 1 frame
- fft_start  out  1  one-cycle start pulse to the FFT
- fft_ch  out  1  channel currently granted
- fft_din  out  NPTS*DATA_W  frame presented to the FFT; stable from START until leaving WAIT
- fft_done  in  1  FFT completion pulse
- frame_done  out  1  one-cycle pulse; granted frame completed
- done_ch  out  1  channel of frame_done
- busy  out  1  high when state is not IDLE
- ovr0, ovr1  out  1  sticky per-channel overrun flags
- ovr_clr  in  1  clears ovr0, ovr1 (and counters, if compiled in)
- timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (synchronous, any state):
  - All outputs, holding buffers, pend0/pend1 and the watchdog counter go to 0.
  - State returns to IDLE.
  - Edge-detect history registers go to 0.
  - Round-robin pointer last_grant goes to 1, so channel 0 wins first.
- Capture:
  - A rising edge of reqX_valid (current 1, registered previous 0) latches frmX into bufX and sets pendX at that clock edge.
  - A level held high causes exactly one capture.
- Overrun:
  - A rising edge while pendX is already 1 and not being consumed this cycle overwrites bufX with the newest frame and sets ovrX.
  - Capture coinciding with consumption of the same channel: the old buffer contents go to fft_din, the new frame goes to bufX, pendX stays 1, no overrun.
- FSM IDLE -> START -> WAIT -> IDLE:
  - IDLE: if exactly one pendX is set, grant that channel. If both are set, grant the channel != last_grant. On grant, load fft_din <= bufX, set fft_ch and last_grant, clear pendX, go to START.
  - START: fft_start = 1 for exactly this cycle; go to WAIT; fft_done is ignored in this state.
  - WAIT, fft_done = 1: frame_done = 1 and done_ch = fft_ch on the next cycle; return to IDLE.
  - WAIT, watchdog reaches TIMEOUT cycles (TIMEOUT != 0): pulse timeout, drop the frame (no frame_done), return to IDLE.
- fft_done outside WAIT is ignored.
- Latency:
  - Rising edge sampled at edge k with IDLE and no contention: fft_start is high in the cycle after edge k+1.
  - The next grant can occur in the cycle after returning to IDLE, giving back-to-back frames with one IDLE cycle between them.
- Reset mid-WAIT abandons the frame silently.

Optional Feature:
- Macro FFT_ARB_OVR_CNT_EN.
- Defined:
  - Adds outputs ovr_cnt0 and ovr_cnt1, each 8 bits.
  - Each counts overrun events, saturating at 255.
  - Cleared by rst or ovr_clr. If ovr_clr and an overrun occur in the same cycle, the counter reads 1.
- Undefined: the ports and counters are absent; only the sticky flags exist.

Test Plan:
- Single frame: frm0 = samples 0x0000..0x000F, rising req0_valid at edge k.
  - Expect fft_start in the cycle after edge k+1, fft_ch = 0, fft_din equal to frm0.
  - fft_done 10 cycles later -> frame_done = 1 with done_ch = 0; busy low the next cycle.
- Contention: req0 and req1 rise in the same cycle after reset.
  - Expect ch0 granted first, ch1 after ch0's done.
  - A second simultaneous pair -> ch0 granted first again (last_grant = 1).
- Overrun: ch0 frame A in WAIT, then frame B (0x1111 pattern) captured, then frame C (0x2222 pattern) captured before done.
  - Expect ovr0 = 1 and the next ch0 grant with fft_din all 0x2222.
  - ovr_clr -> ovr0 = 0; with the macro defined, ovr_cnt0 reads 1 before the clear and 0 after.
- Level hold: req0_valid held high for 40 cycles, fft_done returned normally.
  - Expect exactly one fft_start and one frame_done.
- Watchdog: TIMEOUT = 32, fft_done never asserted.
  - Expect a timeout pulse after 32 WAIT cycles, no frame_done, and a pending ch1 frame granted next.
- Reset mid-WAIT with ch1 pending: pulse rst.
  - Expect busy = 0, pend cleared, no fft_start until a new rising edge; the first grant after reset is ch0.
